// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings, FSM states and defaults for mem_arbiter
package mem_arb_pkg;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [31:0] RPG_BASE_DEFAULT = 32'h0800_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        RPG_ACC = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/ok memory bus shared by the CPU side and the memory side
interface mem_bus_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        read;
    logic        write;
    logic [31:0] rdata;
    logic        ok;

    modport master (output addr, wdata, width, read, write, input rdata, ok);
    modport slave  (input addr, wdata, width, read, write, output rdata, ok);

endinterface

// File: rtl/mem_arbiter_rpg_fifo.sv
// rtl/mem_arbiter_rpg_fifo.sv - synchronous FIFO buffering reprogrammer word writes
module rpg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = store[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU / reprogrammer arbiter for the memory port (optional RPG_CHECKSUM_EN)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          RPG_FIFO_DEPTH = 4,
    parameter logic [31:0] RPG_BASE       = RPG_BASE_DEFAULT,
    parameter int          RPG_AW         = 13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rpg_mode,
    mem_bus_if.slave          cpu,
    input  logic [RPG_AW-1:0] rpg_addr,
    input  logic [31:0]       rpg_data,
    input  logic              rpg_write,
    output logic              rpg_overflow,
    output logic [7:0]        rpg_xorc,
    mem_bus_if.master         mem
);

    localparam int CW = $clog2(RPG_FIFO_DEPTH) + 1;

    arb_state_t            state, next_state;
    logic [RPG_AW+31:0]    head;
    logic [RPG_AW-1:0]     head_addr;
    logic [31:0]           head_data;
    logic                  fifo_full, fifo_empty, rpg_pop;
    logic [CW-1:0]         fifo_count;

    assign head_addr = head[RPG_AW+31:32];
    assign head_data = head[31:0];
    assign rpg_pop   = (state == RPG_ACC) && mem.ok;

    rpg_fifo #(.DEPTH(RPG_FIFO_DEPTH), .WIDTH(RPG_AW + 32)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rpg_write),
        .push_data ({rpg_addr, rpg_data}),
        .pop       (rpg_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    // A nearly-full FIFO preempts the CPU so reprogrammer strobes are not lost.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty && (rpg_mode || fifo_count >= CW'(RPG_FIFO_DEPTH - 1)))
                    next_state = RPG_ACC;
                else if (!rpg_mode && (cpu.read || cpu.write))
                    next_state = CPU_ACC;
                else if (!fifo_empty)
                    next_state = RPG_ACC;
            end
            CPU_ACC, RPG_ACC: if (mem.ok) next_state = DONE;
            DONE:             next_state = IDLE;
            default:          next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem.addr  <= '0;
            mem.wdata <= '0;
            mem.width <= '0;
            mem.read  <= 1'b0;
            mem.write <= 1'b0;
        end else begin
            case (next_state)
                CPU_ACC: begin
                    mem.addr  <= cpu.addr;
                    mem.wdata <= cpu.wdata;
                    mem.width <= cpu.width;
                    mem.read  <= cpu.read;
                    mem.write <= cpu.write && !cpu.read;
                end
                RPG_ACC: begin
                    mem.addr  <= RPG_BASE + {{(30 - RPG_AW){1'b0}}, head_addr, 2'b00};
                    mem.wdata <= head_data;
                    mem.width <= W_WORD;
                    mem.read  <= 1'b0;
                    mem.write <= 1'b1;
                end
                default: begin
                    mem.addr  <= '0;
                    mem.wdata <= '0;
                    mem.width <= '0;
                    mem.read  <= 1'b0;
                    mem.write <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu.ok       <= 1'b0;
            cpu.rdata    <= '0;
            rpg_overflow <= 1'b0;
        end else begin
            cpu.ok <= (state == CPU_ACC) && mem.ok;
            if ((state == CPU_ACC) && mem.ok) cpu.rdata <= mem.rdata;
            if (rpg_write && fifo_full && !rpg_pop) rpg_overflow <= 1'b1;
        end
    end

`ifdef RPG_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rpg_xorc <= 8'h00;
        else if (rpg_pop)
            rpg_xorc <= rpg_xorc ^ head_data[31:24] ^ head_data[23:16]
                                 ^ head_data[15:8]  ^ head_data[7:0];
    end
`else
    assign rpg_xorc = 8'h00;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rpg_mode;
    logic [12:0] rpg_addr;
    logic [31:0] rpg_data;
    logic        rpg_write;
    logic        rpg_overflow;
    logic [7:0]  rpg_xorc;

    mem_bus_if cpu_bus ();
    mem_bus_if mem_bus ();

    mem_arbiter #(
        .RPG_FIFO_DEPTH (4),
        .RPG_BASE       (32'h0800_0000),
        .RPG_AW         (13)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rpg_mode     (rpg_mode),
        .cpu          (cpu_bus),
        .rpg_addr     (rpg_addr),
        .rpg_data     (rpg_data),
        .rpg_write    (rpg_write),
        .rpg_overflow (rpg_overflow),
        .rpg_xorc     (rpg_xorc),
        .mem          (mem_bus)
    );

    always #10 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mem_hold;
    logic [31:0] mem_rval;
    int          mem_cnt;
    int          cpu_ok_cnt;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Memory model: completes each request MEM_LAT cycles after it appears, unless held.
    always @(posedge clk) begin
        if (!rstn) begin
            mem_bus.ok    <= 1'b0;
            mem_bus.rdata <= '0;
            mem_cnt       <= 0;
        end else begin
            mem_bus.ok <= 1'b0;
            if ((mem_bus.read || mem_bus.write) && !mem_bus.ok && !mem_hold) begin
                if (mem_cnt == MEM_LAT - 1) begin
                    mem_bus.ok    <= 1'b1;
                    mem_bus.rdata <= mem_rval;
                    mem_cnt       <= 0;
                    if (mem_bus.write) begin
                        wr_addr_q.push_back(mem_bus.addr);
                        wr_data_q.push_back(mem_bus.wdata);
                    end
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end else begin
                mem_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) cpu_ok_cnt <= 0;
        else if (cpu_bus.ok) cpu_ok_cnt <= cpu_ok_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [12:0] a, input logic [31:0] d);
        rpg_addr  = a;
        rpg_data  = d;
        rpg_write = 1'b1;
        @(posedge clk);
        #1;
        rpg_write = 1'b0;
    endtask

    task automatic cpu_read_txn(input logic [31:0] a, output int lat,
                                output logic [31:0] rd, output logic single);
        lat = -1;
        rd  = '0;
        cpu_bus.addr  = a;
        cpu_bus.width = W_WORD;
        cpu_bus.read  = 1'b1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            @(negedge clk);
            if (cpu_bus.ok) begin
                lat = i;
                rd  = cpu_bus.rdata;
                cpu_bus.read = 1'b0;
            end
        end
        cpu_bus.read = 1'b0;
        @(negedge clk);
        single = !cpu_bus.ok;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int base, input int n, input int budget);
        for (int i = 0; i < budget && (wr_addr_q.size() - base) < n; i++) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          base;
        int          ok0;
        logic [31:0] rd;
        logic        single;
        logic        seen;
        logic        saw_ok;
        logic        got;
        logic [31:0] cap_addr, cap_data;
        logic [1:0]  cap_width;

        rstn = 1'b0; rpg_mode = 1'b0; rpg_write = 1'b0; rpg_addr = '0; rpg_data = '0;
        cpu_bus.addr = '0; cpu_bus.wdata = '0; cpu_bus.width = '0;
        cpu_bus.read = 1'b0; cpu_bus.write = 1'b0;
        mem_hold = 1'b0; mem_rval = 32'hDEAD_BEEF;
        tick(3);
        check("rst_cpu_ok",   {31'b0, cpu_bus.ok},   32'h0);
        check("rst_mem_read", {31'b0, mem_bus.read}, 32'h0);
        check("rst_mem_wr",   {31'b0, mem_bus.write}, 32'h0);
        check("rst_mem_addr", mem_bus.addr,          32'h0);
        check("rst_ovf",      {31'b0, rpg_overflow}, 32'h0);
        check("rst_xorc",     {24'b0, rpg_xorc},     32'h0);
        rstn = 1'b1;
        tick(2);

        // 1: plain CPU read, memory latency 3 -> cpu_ok 5 cycles after request
        cpu_read_txn(32'h0300_0010, lat, rd, single);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_rdata",   rd,       32'hDEAD_BEEF);
        check("t1_single",  {31'b0, single}, 32'h1);

        // 2: reprogram mode blocks the CPU, word lands in the ROM window
        rpg_mode = 1'b1;
        cpu_bus.addr = 32'h0300_0020; cpu_bus.read = 1'b1;
        tick(1);
        base = wr_addr_q.size();
        strobe(13'h0005, 32'h1122_3344);
        seen = 1'b0; saw_ok = 1'b0; cap_addr = '0; cap_data = '0; cap_width = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_bus.ok) saw_ok = 1'b1;
            if (mem_bus.write && !seen) begin
                seen = 1'b1;
                cap_addr = mem_bus.addr; cap_width = mem_bus.width; cap_data = mem_bus.wdata;
            end
        end
        check("t2_write_seen", {31'b0, seen},      32'h1);
        check("t2_addr",       cap_addr,           32'h0800_0014);
        check("t2_width",      {30'b0, cap_width}, 32'h2);
        check("t2_wdata",      cap_data,           32'h1122_3344);
        check("t2_cpu_stall",  {31'b0, saw_ok},    32'h0);
        check("t2_nwrites",    32'(wr_addr_q.size() - base), 32'd1);
        cpu_bus.read = 1'b0;
        tick(1);
        rpg_mode = 1'b0;

        // 3: CPU keeps winning until three words are queued
        base = wr_addr_q.size();
        ok0  = cpu_ok_cnt;
        cpu_bus.addr = 32'h0300_0000; cpu_bus.read = 1'b1;
        strobe(13'h0100, 32'hA1A1_0001);
        tick(20);
        check("t3_cpu_wins_1", 32'(wr_addr_q.size() - base), 32'd0);
        strobe(13'h0101, 32'hA2A2_0002);
        tick(20);
        check("t3_cpu_wins_2", 32'(wr_addr_q.size() - base), 32'd0);
        check("t3_cpu_progress", {31'b0, (cpu_ok_cnt - ok0) > 2}, 32'h1);
        strobe(13'h0102, 32'hA3A3_0003);
        wait_writes(base, 1, 40);
        check("t3_first_grant", 32'(wr_addr_q.size() - base), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cpu_bus.ok) begin got = 1'b1; cpu_bus.read = 1'b0; end
        end
        cpu_bus.read = 1'b0;
        check("t3_cpu_after", {31'b0, got}, 32'h1);
        wait_writes(base, 3, 60);
        check("t3_nwrites", 32'(wr_addr_q.size() - base), 32'd3);
        if (wr_addr_q.size() - base >= 3) begin
            check("t3_addr0", wr_addr_q[base],     32'h0800_0400);
            check("t3_data0", wr_data_q[base],     32'hA1A1_0001);
            check("t3_data1", wr_data_q[base + 1], 32'hA2A2_0002);
            check("t3_addr2", wr_addr_q[base + 2], 32'h0800_0408);
            check("t3_data2", wr_data_q[base + 2], 32'hA3A3_0003);
        end
        tick(2);

        // 4: five strobes into a depth-4 FIFO while memory stalls
        base = wr_addr_q.size();
        mem_hold = 1'b1;
        rpg_mode = 1'b1;
        for (int i = 0; i < 5; i++) strobe(13'(16 + i), 32'hB000_0000 + 32'(i));
        tick(2);
        check("t4_overflow", {31'b0, rpg_overflow}, 32'h1);
        check("t4_stalled",  32'(wr_addr_q.size() - base), 32'd0);
        mem_hold = 1'b0;
        wait_writes(base, 4, 80);
        tick(15);
        check("t4_nwrites", 32'(wr_addr_q.size() - base), 32'd4);
        if (wr_addr_q.size() - base >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t4_addr%0d", i), wr_addr_q[base + i], 32'h0800_0040 + 32'(4 * i));
                check($sformatf("t4_data%0d", i), wr_data_q[base + i], 32'hB000_0000 + 32'(i));
            end
        end
        check("t4_ovf_sticky", {31'b0, rpg_overflow}, 32'h1);

        // 5: asynchronous reset in the middle of a CPU access
        rpg_mode = 1'b0;
        mem_hold = 1'b1;
        cpu_bus.addr = 32'h0300_0040; cpu_bus.read = 1'b1;
        tick(4);
        strobe(13'h0007, 32'hCAFE_0001);
        check("t5_in_cpu_acc", {31'b0, mem_bus.read}, 32'h1);
        #5;
        rstn = 1'b0;
        #1;
        check("t5_rst_read",  {31'b0, mem_bus.read},  32'h0);
        check("t5_rst_write", {31'b0, mem_bus.write}, 32'h0);
        check("t5_rst_addr",  mem_bus.addr,           32'h0);
        check("t5_rst_ok",    {31'b0, cpu_bus.ok},    32'h0);
        check("t5_rst_ovf",   {31'b0, rpg_overflow},  32'h0);
        cpu_bus.read = 1'b0;
        mem_hold = 1'b0;
        tick(2);
        rstn = 1'b1;
        base = wr_addr_q.size();
        rpg_mode = 1'b1;
        tick(15);
        check("t5_fifo_empty", 32'(wr_addr_q.size() - base), 32'd0);
        rpg_mode = 1'b0;
        tick(1);
        mem_rval = 32'h1234_5678;
        cpu_read_txn(32'h0300_0050, lat, rd, single);
        check("t5_latency", 32'(lat), 32'd5);
        check("t5_rdata",   rd,       32'h1234_5678);

        // 6: running checksum over committed reprogram words
        base = wr_addr_q.size();
        rpg_mode = 1'b1;
        strobe(13'h0000, 32'h0102_0304);
        strobe(13'h0001, 32'h1000_0000);
        wait_writes(base, 2, 40);
        tick(4);
        check("t6_nwrites", 32'(wr_addr_q.size() - base), 32'd2);
`ifdef RPG_CHECKSUM_EN
        check("t6_xorc", {24'b0, rpg_xorc}, 32'h14);
`else
        check("t6_xorc", {24'b0, rpg_xorc}, 32'h00);
`endif
        rpg_mode = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port arbiter in front of the system memory block. Shares the one memory request port between two requesters:
- the CPU bus (addr/data/width/read/write/ok handshake);
- the UART reprogrammer's fire-and-forget word-write stream, buffered in a small FIFO.
Sits between cpu_armv4t / reprogram and memory. Reprogrammed words land in the cartridge ROM window.

Parameters:
RPG_FIFO_DEPTH, 4, reprogrammer write FIFO entries (power of two, >=2)
RPG_BASE, 32'h0800_0000, byte base address of reprogram window
RPG_AW, 13, reprogrammer word-address width

Ports:
clk  in  1  system clock (50 MHz)
rstn  in  1  asynchronous active-low reset
rpg_mode  in  1  reprogram mode (switch); 1 = CPU blocked
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU write data
cpu_width  in  2  00 byte, 01 half, 10 word
cpu_read  in  1  CPU read request, held until cpu_ok
cpu_write  in  1  CPU write request, held until cpu_ok
cpu_rdata  out  32  read data, valid while cpu_ok=1
cpu_ok  out  1  one-cycle completion pulse
rpg_addr  in  RPG_AW  word address from reprogrammer
rpg_data  in  32  word data
rpg_write  in  1  one-cycle write strobe
rpg_overflow  out  1  sticky: strobe dropped on full FIFO
rpg_xorc  out  8  running checksum (see Optional Feature)
mem_addr  out  32  memory byte address
mem_wdata  out  32  memory write data
mem_width  out  2  memory access width
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_rdata  in  32  memory read data
mem_ok  in  1  memory completion pulse

Behaviour:
- Reset (rstn low, async): FSM=IDLE, FIFO empty. All outputs 0, including rpg_overflow and rpg_xorc. An in-flight access is abandoned. The memory must tolerate a request dropping mid-access.
- FSM states: IDLE, CPU_ACC, RPG_ACC, DONE. All mem_* outputs are registered.
- IDLE arbitration, evaluated in priority order:
  (a) FIFO non-empty and (rpg_mode=1 or count >= RPG_FIFO_DEPTH-1) -> RPG_ACC;
  (b) rpg_mode=0 and (cpu_read or cpu_write) -> CPU_ACC;
  (c) FIFO non-empty -> RPG_ACC;
  (d) otherwise stay in IDLE.
- cpu_read and cpu_write both high: treated as read.
- Grant latency: mem_read/mem_write assert on the cycle after the IDLE decision and are held until mem_ok.
- CPU_ACC: mem_addr=cpu_addr, mem_width=cpu_width, mem_wdata=cpu_wdata. On mem_ok:
  - capture mem_rdata into cpu_rdata;
  - go to DONE; next cycle cpu_ok=1 and mem_* are deasserted.
  - CPU access latency is therefore mem latency + 2 cycles.
- RPG_ACC: mem_addr = RPG_BASE + {rpg_addr, 2'b00}, mem_width=10, mem_write=1. On mem_ok: pop the FIFO head and go to DONE. cpu_ok stays 0.
- DONE: a single cycle, then IDLE. No new grant is made in DONE. This gives the CPU one cycle to drop its request after cpu_ok.
- rpg_mode rising while in CPU_ACC: the current access completes normally. No further CPU grants are made while rpg_mode=1. cpu_ok stays low and the CPU stalls.
- FIFO push: rpg_write with FIFO not full, or full with a pop in the same cycle, is accepted.
- FIFO overflow: rpg_write with FIFO full and no pop drops the word and sets rpg_overflow. rpg_overflow clears only on reset.
- Push and pop in the same cycle: count is unchanged. FIFO pointers wrap modulo RPG_FIFO_DEPTH.
- mem_ok outside CPU_ACC/RPG_ACC is ignored.

Optional Feature:
RPG_CHECKSUM_EN
- Defined: rpg_xorc is updated at each RPG pop (on mem_ok) with rpg_xorc ^= d[31:24]^d[23:16]^d[15:8]^d[7:0], using the committed word. It matches the reprogrammer's host-side XOR check.
- Undefined: rpg_xorc is tied to 8'h00 and no checksum logic is built.

Decomposition:
- Package mem_arb_pkg: width encodings (W_BYTE=00, W_HALF=01, W_WORD=10), FSM state enum, default RPG_BASE.
- Sub-module rpg_fifo: synchronous FIFO, parameter DEPTH, 45-bit entries (13 addr + 32 data), outputs full/empty/count, same clk/rstn.

Test Plan:
1. Reset, CPU read 0x0300_0010 width 10, memory returns 0xDEADBEEF with mem_ok 3 cycles after mem_read -> cpu_ok one pulse 5 cycles after request, cpu_rdata=0xDEADBEEF.
2. rpg_mode=1, rpg_write addr 0x0005 data 0x11223344 -> mem_write with mem_addr=0x0800_0014, width 10, wdata 0x11223344; CPU request pending throughout sees cpu_ok=0.
3. rpg_mode=0, continuous CPU reads, 3 rpg strobes -> CPU keeps winning until FIFO count=3, then RPG_ACC is granted; all 3 words are written in order.
4. rpg_mode=1, mem_ok withheld, 5 back-to-back strobes (depth 4) -> rpg_overflow=1, 4 words written once mem_ok resumes, the 5th is absent.
5. rstn pulsed low mid CPU_ACC -> all outputs 0 immediately, FIFO empty, rpg_overflow=0; a new request completes normally.
6. With RPG_CHECKSUM_EN, words 0x01020304 and 0x10000000 written -> rpg_xorc=0x14. Without the macro -> rpg_xorc=0x00.
